// File: rtl/alu_unit_if.sv
// Operand/result bundle between the register-file read side and the ALU.
// The zero and carry flags exist only when ALU_FLAGS_EN is defined.
interface alu_unit_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         alu_control;
    logic [2*WIDTH:0]   result;
    logic               out_valid;
`ifdef ALU_FLAGS_EN
    logic               zero;
    logic               carry;
`endif

`ifdef ALU_FLAGS_EN
    modport master (
        output in_valid, a, b, alu_control,
        input  result, out_valid, zero, carry
    );

    modport slave (
        input  in_valid, a, b, alu_control,
        output result, out_valid, zero, carry
    );
`else
    modport master (
        output in_valid, a, b, alu_control,
        input  result, out_valid
    );

    modport slave (
        input  in_valid, a, b, alu_control,
        output result, out_valid
    );
`endif
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU: 3-bit opcode, 1-cycle latency, result 2*WIDTH+1 bits.
// Optional flags (zero, carry) are built when ALU_FLAGS_EN is defined.
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_unit_if.slave   bus
);
    localparam int RW  = 2 * WIDTH + 1;
    // Wide enough to hold a << 15 so bits shifted past the result can be seen.
    localparam int SHW = RW + 15;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    op_e            op;
    logic [RW-1:0]  ext_a;
    logic [RW-1:0]  ext_b;
    logic [RW-1:0]  sum;
    logic [RW-1:0]  diff;
    logic [RW-1:0]  prod;
    logic [SHW-1:0] shl_full;
    logic [RW-1:0]  next_result;
`ifdef ALU_FLAGS_EN
    logic           next_carry;
`endif

    assign op    = op_e'(bus.alu_control);
    assign ext_a = {{(RW-WIDTH){1'b0}}, bus.a};
    assign ext_b = {{(RW-WIDTH){1'b0}}, bus.b};

    // Datapath for every opcode; the selected value feeds the result register.
    always_comb begin
        sum         = ext_a + ext_b;
        diff        = ext_a - ext_b;
        prod        = ext_a * ext_b;
        shl_full    = {{(SHW-WIDTH){1'b0}}, bus.a} << bus.b[3:0];
        next_result = '0;
`ifdef ALU_FLAGS_EN
        next_carry  = 1'b0;
`endif
        unique case (op)
            OP_ADD: begin
                next_result = sum;
`ifdef ALU_FLAGS_EN
                next_carry  = sum[WIDTH];
`endif
            end
            OP_SUB: begin
                next_result = diff;
`ifdef ALU_FLAGS_EN
                next_carry  = (bus.a < bus.b);
`endif
            end
            OP_MUL: begin
                next_result = prod;
`ifdef ALU_FLAGS_EN
                next_carry  = |prod[RW-1:WIDTH];
`endif
            end
            OP_AND: next_result = ext_a & ext_b;
            OP_OR:  next_result = ext_a | ext_b;
            OP_XOR: next_result = ext_a ^ ext_b;
            OP_SHL: begin
                next_result = shl_full[RW-1:0];
`ifdef ALU_FLAGS_EN
                next_carry  = |shl_full[SHW-1:RW];
`endif
            end
            OP_SHR: next_result = ext_a >> bus.b[2:0];
        endcase
    end

    // Output register: reset clears, in_valid loads, otherwise result and flags hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            bus.zero      <= 1'b1;
            bus.carry     <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result <= next_result;
`ifdef ALU_FLAGS_EN
                bus.zero   <= (next_result == '0);
                bus.carry  <= next_carry;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver queues expected results at issue,
// a negedge monitor pops and compares whenever out_valid is high.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_unit;
    typedef struct {
        logic [16:0] r;
        logic        z;
        logic        c;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_unit_if #(.WIDTH(8)) bus ();

    alu_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Independent reference model used for the random phase.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   ia = int'(x);
        int   ib = int'(y);
        int   full;
        e.c = 1'b0;
        case (op)
            3'd0: begin full = ia + ib; e.c = (full > 255); end
            3'd1: begin full = ia - ib; e.c = (ia < ib); end
            3'd2: begin full = ia * ib; e.c = (full > 255); end
            3'd3: full = ia & ib;
            3'd4: full = ia | ib;
            3'd5: full = ia ^ ib;
            3'd6: begin full = ia << (ib % 16); e.c = ((full >>> 17) != 0); end
            default: full = ia >> (ib % 8);
        endcase
        e.r    = full[16:0];
        e.z    = (e.r == 17'd0);
        e.name = "random";
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a           = x;
        bus.b           = y;
        bus.alu_control = op;
        sb.push_back(e);
    endtask

    function automatic exp_t mk(input logic [16:0] r, input logic z, input logic c, input string n);
        exp_t e;
        e.r = r; e.z = z; e.c = c; e.name = n;
        return e;
    endfunction

    // Monitor: every valid result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 32'(bus.result), 32'(e.r));
`ifdef ALU_FLAGS_EN
                check({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
                check({e.name, "_carry"}, 32'(bus.carry), 32'(e.c));
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [16:0] sweep_r [8] = '{17'd3, 17'd1, 17'd2, 17'd0, 17'd3, 17'd3, 17'd4, 17'd1};

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.alu_control = '0;
        repeat (2) @(negedge clk);

        // Reset overrides an op presented in the same cycle.
        bus.in_valid = 1'b1; bus.a = 8'd2; bus.b = 8'd1; bus.alu_control = 3'b000;
        @(negedge clk);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef ALU_FLAGS_EN
        check("reset_zero", 32'(bus.zero), 32'd1);
        check("reset_carry", 32'(bus.carry), 32'd0);
`endif
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);

        // Opcode sweep with a=2, b=1, back to back.
        for (int i = 0; i < 8; i++)
            issue(3'(i), 8'd2, 8'd1, mk(sweep_r[i], (i == 3), 1'b0, $sformatf("sweep_op%0d", i)));

        // Arithmetic edges.
        issue(3'b000, 8'hFF, 8'hFF, mk(17'h001FE, 1'b0, 1'b1, "add_255_255"));
        issue(3'b001, 8'd1,  8'd2,  mk(17'h1FFFF, 1'b0, 1'b1, "sub_1_2"));
        issue(3'b010, 8'hFF, 8'hFF, mk(17'h0FE01, 1'b0, 1'b1, "mul_255_255"));
        issue(3'b001, 8'd0,  8'd0,  mk(17'h00000, 1'b1, 1'b0, "sub_0_0"));
        // Shift masking: 0x81 << 15 leaves only bit 15 inside 17 bits; bit 22 is lost.
        issue(3'b110, 8'h81, 8'h1F, mk(17'h08000, 1'b0, 1'b1, "shl_81_15"));
        issue(3'b111, 8'h81, 8'hFF, mk(17'h00001, 1'b0, 1'b0, "shr_81_7"));

        // Hold: in_valid low, inputs wandering, result stays at 1.
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = 8'h55; bus.b = 8'hAA; bus.alu_control = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("hold%0d_result", i), 32'(bus.result), 32'd1);
`ifdef ALU_FLAGS_EN
            check($sformatf("hold%0d_zero", i), 32'(bus.zero), 32'd0);
            check($sformatf("hold%0d_carry", i), 32'(bus.carry), 32'd0);
`endif
            bus.a = 8'(bus.a + 8'd17); bus.b = 8'(bus.b - 8'd3);
            bus.alu_control = 3'(bus.alu_control + 3'd1);
        end

        // Reset mid-stream: the op presented during reset is dropped.
        issue(3'b000, 8'd10, 8'd20, mk(17'd30, 1'b0, 1'b0, "pre_reset_add"));
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b1; bus.a = 8'd7; bus.b = 8'd7; bus.alu_control = 3'b000;
        @(negedge clk);
        check("midreset_result", 32'(bus.result), 32'd0);
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("midreset_drop", 32'(bus.out_valid), 32'd0);

        // Random back-to-back traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] op;
            logic [7:0] x;
            logic [7:0] y;
            op = 3'($urandom_range(0, 7));
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            issue(op, x, y, model(op, x, y));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
